pipe_ctrl: RTL

Pipeline hazard and redirect controller for the 16-bit, 7-bit-PC, 8-register five-stage core. It sits beside the ID/EX and IF/ID pipeline registers.

- **Drives:** the flush lines those registers consume (asserting flush loads the NOP instruction and zero operands), the hold lines for PC, IF/ID and ID/EX, and the PC redirect.
- **Resolves:** branch/jump redirects from EX, load-use hazards detected in ID, and freezes while a multi-cycle EX unit is busy.
- **Counts:** flush and stall cycles for performance debug.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/pipe_ctrl_sat_counter.sv | 16 +
 rtl/pipe_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the five-stage core's hazard/redirect controller:
// datapath widths, FSM encoding and the NOP instruction word.
package pipe_ctrl_pkg;
  localparam int PC_W   = 7;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  localparam logic [DATA_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_BUSY  = 2'd2
  } state_t;
endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the flush/stall performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && count != '1)
      count <= count + 1'b1;
  end
endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and redirect controller: drives flush/hold/bubble lines and the PC
// redirect for the IF/ID and ID/EX registers, plus perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jump_req_i,
  input  logic [PC_W-1:0]  jump_addr_i,
  input  logic             ex_busy_i,
  input  logic             ex_is_load_i,
  input  logic             ex_reg_wen_i,
  input  logic [REG_W-1:0] ex_rd_addr_i,
  input  logic             id_rs1_ren_i,
  input  logic             id_rs2_ren_i,
  input  logic [REG_W-1:0] id_rs1_addr_i,
  input  logic [REG_W-1:0] id_rs2_addr_i,
  output logic             jump_en_o,
  output logic [PC_W-1:0]  jump_addr_o,
  output logic             pc_load_o,
  output logic             hold_pc_o,
  output logic             hold_if_id_o,
  output logic             hold_id_ex_o,
  output logic             bubble_id_ex_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam bit         HAS_FLUSH  = (FLUSH_CYCLES > 1);

  state_t     state, state_nxt;
  logic [2:0] flush_left, flush_left_nxt;
  logic       lu_hazard;
  logic [CNT_W-1:0] flush_cnt, stall_cnt;

  // x0 is deliberately not special-cased: the core's register 0 is writable.
  assign lu_hazard = ex_is_load_i & ex_reg_wen_i &
                     ((id_rs1_ren_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                      (id_rs2_ren_i & (id_rs2_addr_i == ex_rd_addr_i)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      flush_left <= '0;
    end else begin
      state      <= state_nxt;
      flush_left <= flush_left_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    flush_left_nxt = flush_left;
    if (jump_req_i) begin
      state_nxt      = HAS_FLUSH ? S_FLUSH : S_IDLE;
      flush_left_nxt = HAS_FLUSH ? FLUSH_INIT : 3'd0;
    end else begin
      case (state)
        S_FLUSH: begin
          flush_left_nxt = flush_left - 3'd1;
          if (flush_left <= 3'd1) begin
            state_nxt      = S_IDLE;
            flush_left_nxt = '0;
          end
        end
        S_BUSY:  state_nxt = ex_busy_i ? S_BUSY : S_IDLE;
        default: state_nxt = ex_busy_i ? S_BUSY : S_IDLE;
      endcase
    end
  end

  // Busy and flush both mask load-use; the cycle busy drops issues nothing.
  always_comb begin
    jump_en_o      = 1'b0;
    pc_load_o      = 1'b0;
    jump_addr_o    = '0;
    hold_pc_o      = 1'b0;
    hold_if_id_o   = 1'b0;
    hold_id_ex_o   = 1'b0;
    bubble_id_ex_o = 1'b0;
    if (!rst) begin
      if (jump_req_i) begin
        jump_en_o   = 1'b1;
        pc_load_o   = 1'b1;
        jump_addr_o = jump_addr_i;
      end else begin
        case (state)
          S_FLUSH: jump_en_o = 1'b1;
          S_BUSY: begin
            hold_pc_o    = ex_busy_i;
            hold_if_id_o = ex_busy_i;
            hold_id_ex_o = ex_busy_i;
          end
          default: begin
            if (ex_busy_i) begin
              hold_pc_o    = 1'b1;
              hold_if_id_o = 1'b1;
              hold_id_ex_o = 1'b1;
            end else if (lu_hazard) begin
              hold_pc_o      = 1'b1;
              hold_if_id_o   = 1'b1;
              bubble_id_ex_o = 1'b1;
            end
          end
        endcase
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (jump_en_o),
    .count (flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hold_pc_o),
    .count (stall_cnt)
  );

  assign flush_cnt_o = rst ? '0 : flush_cnt;
  assign stall_cnt_o = rst ? '0 : stall_cnt;
endmodule
